// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-read-port register file.
//   DEF_DATA_W / DEF_ADDR_W : default register width and address width
//   regfile_state_t         : clear-sweep controller state (CLEAR, RUN)
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } regfile_state_t;

endpackage

// File: rtl/regfile_clear_ctl.sv
// regfile_clear_ctl: post-reset clear sweep controller for regfile_mp.
// Walks every entry index once after reset, requesting a zero write per cycle,
// then parks in RUN and reports ready.
// Ports:
//   i_clock     rising-edge clock
//   i_reset     synchronous active-high reset; restarts the sweep
//   o_ready     high in RUN (forced low while i_reset is high)
//   o_clr_we    request to write zero to entry o_clr_idx this cycle
//   o_clr_idx   current sweep index
module regfile_clear_ctl
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              i_clock,
    input  logic              i_reset,
    output logic              o_ready,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_idx
);

    regfile_state_t    r_state;
    regfile_state_t    w_state_next;
    logic [ADDR_W-1:0] r_clr_idx;
    logic [ADDR_W-1:0] w_clr_idx_next;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_idx <= w_clr_idx_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_idx_next = r_clr_idx;
        unique case (r_state)
            CLEAR: begin
                // Index wraps to 0 naturally after the last entry.
                w_clr_idx_next = r_clr_idx + ADDR_W'(1);
                if (&r_clr_idx) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_state_next = RUN;
            end
            default: begin
                w_state_next = CLEAR;
            end
        endcase
    end

    // Gate with reset so the reset cycle itself neither writes nor reports ready.
    assign o_clr_we  = (r_state == CLEAR) && !i_reset;
    assign o_ready   = (r_state == RUN) && !i_reset;
    assign o_clr_idx = r_clr_idx;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with NREAD combinational read ports,
// one write port, hardwired-zero entry 0 and a sequential clear after reset.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
// Ports:
//   clock    rising-edge clock
//   reset    synchronous active-high reset; starts the clear sweep
//   rd_addr  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data  packed read data, port k at [k*DATA_W +: DATA_W]
//   wr_en    write enable (honoured only when ready)
//   wr_addr  write address (address 0 is dropped)
//   wr_data  write data
//   ready    high once the clear sweep has finished
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NREAD  = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    ready
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_ready;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_idx;
    logic              w_user_we;

    regfile_clear_ctl #(
        .ADDR_W (ADDR_W)
    ) u_clear_ctl (
        .i_clock   (clock),
        .i_reset   (reset),
        .o_ready   (w_ready),
        .o_clr_we  (w_clr_we),
        .o_clr_idx (w_clr_idx)
    );

    assign ready     = w_ready;
    assign w_user_we = w_ready && wr_en && (wr_addr != '0);

    // Clear sweep and user writes are mutually exclusive (CLEAR vs RUN).
    always_ff @(posedge clock) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= '0;
        end else if (w_user_we) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;

        assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            w_data = '0;
            if (w_ready && (w_addr != '0)) begin
                w_data = r_mem[w_addr];
`ifdef REGFILE_BYPASS_EN
                if (w_user_we && (wr_addr == w_addr)) begin
                    w_data = wr_data;
                end
`endif
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = w_data;
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A: defaults (32 x 32, two read ports)
    logic        reset_a;
    logic [9:0]  rd_addr_a;
    logic [63:0] rd_data_a;
    logic        wr_en_a;
    logic [4:0]  wr_addr_a;
    logic [31:0] wr_data_a;
    logic        ready_a;

    // Instance B: 16 x 16, three read ports
    logic        reset_b;
    logic [11:0] rd_addr_b;
    logic [47:0] rd_data_b;
    logic        wr_en_b;
    logic [3:0]  wr_addr_b;
    logic [15:0] wr_data_b;
    logic        ready_b;

    regfile_mp u_dut_a (
        .clock   (clock),
        .reset   (reset_a),
        .rd_addr (rd_addr_a),
        .rd_data (rd_data_a),
        .wr_en   (wr_en_a),
        .wr_addr (wr_addr_a),
        .wr_data (wr_data_a),
        .ready   (ready_a)
    );

    regfile_mp #(
        .DATA_W (16),
        .ADDR_W (4),
        .NREAD  (3)
    ) u_dut_b (
        .clock   (clock),
        .reset   (reset_b),
        .rd_addr (rd_addr_b),
        .rd_data (rd_data_b),
        .wr_en   (wr_en_b),
        .wr_addr (wr_addr_b),
        .wr_data (wr_data_b),
        .ready   (ready_b)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] val_b(input int a);
        logic [15:0] v;
        v = (a == 0) ? 16'h0000 : (16'h0101 * 16'(a)) ^ 16'h5A00;
        return v;
    endfunction

    int          cnt;
    int          cnt_b;
    logic [63:0] acc;
    int          a0, a1, a2;
    logic [31:0] exp_bypass;

    initial begin
        reset_a   = 1'b1;
        reset_b   = 1'b1;
        rd_addr_a = '0;
        wr_en_a   = 1'b1;   // write during reset must be dropped
        wr_addr_a = 5'd3;
        wr_data_a = 32'hFFFF_FFFF;
        rd_addr_b = '0;
        wr_en_b   = 1'b0;
        wr_addr_b = '0;
        wr_data_b = '0;
        #1;

        // Reset held for 3 cycles
        repeat (3) tick();
        rd_addr_a = {5'd3, 5'd3};
        #1;
        check("ready_in_reset", 64'(ready_a), 64'd0);
        check("rd_in_reset", rd_data_a, 64'd0);

        // Release; count cycles until ready, write kept asserted to r3 throughout
        reset_a = 1'b0;
        reset_b = 1'b0;
        cnt   = 0;
        cnt_b = 0;
        while (!ready_a && cnt < 100) begin
            tick();
            cnt++;
            if (ready_b && cnt_b == 0) cnt_b = cnt;
        end
        wr_en_a = 1'b0;
        check("ready_latency_a", 64'(cnt), 64'd32);
        check("ready_latency_b", 64'(cnt_b), 64'd16);
        check("ready_high_a", 64'(ready_a), 64'd1);

        // All entries zero, including r3 which saw writes during CLEAR
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = {5'(31 - i), 5'(i)};
            #1;
            acc = acc | rd_data_a;
        end
        check("all_zero_after_clear", acc, 64'd0);

        // Write r5, read on both ports next cycle
        wr_en_a   = 1'b1;
        wr_addr_a = 5'd5;
        wr_data_a = 32'hDEAD_BEEF;
        tick();
        wr_en_a   = 1'b0;
        rd_addr_a = {5'd5, 5'd5};
        #1;
        check("r5_port0", 64'(rd_data_a[31:0]), 64'hDEAD_BEEF);
        check("r5_port1", 64'(rd_data_a[63:32]), 64'hDEAD_BEEF);

        // Write to r0 dropped; also same-cycle read of r0 is zero in both builds
        wr_en_a   = 1'b1;
        wr_addr_a = 5'd0;
        wr_data_a = 32'h1234_5678;
        rd_addr_a = {5'd5, 5'd0};
        #1;
        check("r0_same_cycle", 64'(rd_data_a[31:0]), 64'd0);
        tick();
        wr_en_a = 1'b0;
        #1;
        check("r0_after_write", 64'(rd_data_a[31:0]), 64'd0);
        check("r5_undisturbed", 64'(rd_data_a[63:32]), 64'hDEAD_BEEF);

        // r7 = 1, then same-cycle write/read of r7
        wr_en_a   = 1'b1;
        wr_addr_a = 5'd7;
        wr_data_a = 32'h0000_0001;
        tick();
        wr_data_a = 32'hA5A5_A5A5;
        rd_addr_a = {5'd5, 5'd7};
`ifdef REGFILE_BYPASS_EN
        exp_bypass = 32'hA5A5_A5A5;
`else
        exp_bypass = 32'h0000_0001;
`endif
        #1;
        check("r7_same_cycle", 64'(rd_data_a[31:0]), 64'(exp_bypass));
        check("r5_no_bypass", 64'(rd_data_a[63:32]), 64'hDEAD_BEEF);
        tick();
        wr_en_a = 1'b0;
        #1;
        check("r7_next_cycle", 64'(rd_data_a[31:0]), 64'hA5A5_A5A5);

        // Reset mid-run, then reset again at sweep index 10
        reset_a = 1'b1;
        tick();
        reset_a   = 1'b0;
        rd_addr_a = {5'd7, 5'd5};
        #1;
        check("ready_low_in_clear", 64'(ready_a), 64'd0);
        check("rd_zero_in_clear", rd_data_a, 64'd0);
        repeat (10) tick();
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        cnt = 0;
        while (!ready_a && cnt < 100) begin
            if (cnt == 20) begin
                wr_en_a   = 1'b1;
                wr_addr_a = 5'd9;
                wr_data_a = 32'hCAFE_F00D;
            end else begin
                wr_en_a = 1'b0;
            end
            tick();
            cnt++;
        end
        wr_en_a = 1'b0;
        check("ready_latency_rerun", 64'(cnt), 64'd32);
        rd_addr_a = {5'd5, 5'd9};
        #1;
        check("r9_write_dropped", 64'(rd_data_a[31:0]), 64'd0);
        check("r5_cleared", 64'(rd_data_a[63:32]), 64'd0);

        // Instance B: fill r1..r15 (write to r0 attempted too)
        check("ready_b_run", 64'(ready_b), 64'd1);
        for (int i = 0; i < 16; i++) begin
            wr_en_b   = 1'b1;
            wr_addr_b = 4'(i);
            wr_data_b = (i == 0) ? 16'hFFFF : val_b(i);
            tick();
        end
        wr_en_b = 1'b0;
        for (int t = 0; t < 6; t++) begin
            case (t)
                0: begin a0 = 1;  a1 = 2;  a2 = 3;  end
                1: begin a0 = 15; a1 = 8;  a2 = 4;  end
                2: begin a0 = 0;  a1 = 15; a2 = 15; end
                3: begin a0 = 9;  a1 = 10; a2 = 11; end
                4: begin a0 = 14; a1 = 0;  a2 = 6;  end
                default: begin a0 = 13; a1 = 12; a2 = 7; end
            endcase
            rd_addr_b = {4'(a2), 4'(a1), 4'(a0)};
            #1;
            check($sformatf("b_port0_r%0d", a0), 64'(rd_data_b[15:0]), 64'(val_b(a0)));
            check($sformatf("b_port1_r%0d", a1), 64'(rd_data_b[31:16]), 64'(val_b(a1)));
            check($sformatf("b_port2_r%0d", a2), 64'(rd_data_b[47:32]), 64'(val_b(a2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
